req_stream_arbiter: RTL and testbench

- Shares one 256-bit AXI-Stream request channel between two request generators (source 0, source 1), e.g. two row-request engines feeding one ECD request path.
- Round-robin arbitration at packet granularity: a grant is held until the granted source's TLAST beat is accepted.
- Enforces one global limit on outstanding requests. Each accepted beat is one request; each `row_complete_in` pulse retires one request.

---
 rtl/req_stream_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_req_stream_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : req_stream_arbiter
// Purpose  : Two-to-one AXI-Stream request arbiter with packet-granular
//            round-robin and a global outstanding-request credit limit.
//            Every accepted beat is one request. Every row_complete_in pulse
//            retires one request.
// Ports    : clk, resetn (async, active-low)
//            row_complete_in            - one pulse per fulfilled request
//            S0_AXIS_*, S1_AXIS_*       - upstream request sources
//            M_AXIS_*                   - merged downstream request stream
//            outstanding                - requests currently in flight
//            busy                       - granted or requests still in flight
//            underflow_err              - sticky: completion seen with none in flight
// Options  : REQ_ARB_STATS_EN adds pkt_count0, pkt_count1 and stall_cycles.
// Revision : 1.0 - initial release
// ============================================================================
module req_stream_arbiter #(
  parameter int DATA_WIDTH      = 256,
  parameter int MAX_OUTSTANDING = 16,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  row_complete_in,
  input  logic [DATA_WIDTH-1:0] S0_AXIS_TDATA,
  input  logic                  S0_AXIS_TVALID,
  input  logic                  S0_AXIS_TLAST,
  output logic                  S0_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0] S1_AXIS_TDATA,
  input  logic                  S1_AXIS_TVALID,
  input  logic                  S1_AXIS_TLAST,
  output logic                  S1_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  output logic [CNT_WIDTH-1:0]  outstanding,
  output logic                  busy,
  output logic                  underflow_err
`ifdef REQ_ARB_STATS_EN
  ,
  output logic [31:0]           pkt_count0,
  output logic [31:0]           pkt_count1,
  output logic [31:0]           stall_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_max_outstanding = CNT_WIDTH'(MAX_OUTSTANDING);

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_rr_ptr;
  logic                 w_next_rr_ptr;
  logic [CNT_WIDTH-1:0] r_outstanding;
  logic                 r_underflow_err;
  logic                 w_credit_ok;
  logic                 w_accept;

  // Credit is judged on the registered count, so a completion frees the
  // channel only from the cycle after it is counted.
  assign w_credit_ok = (r_outstanding < c_max_outstanding);
  assign w_accept    = M_AXIS_TVALID & M_AXIS_TREADY;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_rr_ptr <= w_next_rr_ptr;
    end
  end

  // Next-state: the idle decision is registered, which gives one bubble
  // cycle between packets. A grant is only released by an accepted TLAST.
  always_comb begin
    w_next_state  = r_state;
    w_next_rr_ptr = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (S0_AXIS_TVALID && S1_AXIS_TVALID) begin
          w_next_state = r_rr_ptr ? ST_GRANT1 : ST_GRANT0;
        end else if (S0_AXIS_TVALID) begin
          w_next_state = ST_GRANT0;
        end else if (S1_AXIS_TVALID) begin
          w_next_state = ST_GRANT1;
        end
      end
      ST_GRANT0: begin
        if (w_accept && M_AXIS_TLAST) begin
          w_next_state  = ST_IDLE;
          w_next_rr_ptr = 1'b1;
        end
      end
      ST_GRANT1: begin
        if (w_accept && M_AXIS_TLAST) begin
          w_next_state  = ST_IDLE;
          w_next_rr_ptr = 1'b0;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Datapath mux. TREADY never looks at the source's own TVALID.
  always_comb begin
    M_AXIS_TDATA   = '0;
    M_AXIS_TLAST   = 1'b0;
    M_AXIS_TVALID  = 1'b0;
    S0_AXIS_TREADY = 1'b0;
    S1_AXIS_TREADY = 1'b0;
    case (r_state)
      ST_GRANT0: begin
        M_AXIS_TDATA   = S0_AXIS_TDATA;
        M_AXIS_TLAST   = S0_AXIS_TLAST;
        M_AXIS_TVALID  = S0_AXIS_TVALID & w_credit_ok;
        S0_AXIS_TREADY = M_AXIS_TREADY & w_credit_ok;
      end
      ST_GRANT1: begin
        M_AXIS_TDATA   = S1_AXIS_TDATA;
        M_AXIS_TLAST   = S1_AXIS_TLAST;
        M_AXIS_TVALID  = S1_AXIS_TVALID & w_credit_ok;
        S1_AXIS_TREADY = M_AXIS_TREADY & w_credit_ok;
      end
      default: ;
    endcase
  end

  // Outstanding counter. A completion with nothing in flight (and no
  // simultaneous accept to cancel it) holds at zero and flags the error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_outstanding   <= '0;
      r_underflow_err <= 1'b0;
    end else begin
      case ({w_accept, row_complete_in})
        2'b10: r_outstanding <= r_outstanding + CNT_WIDTH'(1);
        2'b01: begin
          if (r_outstanding != '0) begin
            r_outstanding <= r_outstanding - CNT_WIDTH'(1);
          end else begin
            r_underflow_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign outstanding   = r_outstanding;
  assign underflow_err = r_underflow_err;
  assign busy          = (r_state != ST_IDLE) || (r_outstanding != '0);

`ifdef REQ_ARB_STATS_EN
  logic [31:0] r_pkt_count0;
  logic [31:0] r_pkt_count1;
  logic [31:0] r_stall_cycles;
  logic        w_stalled;

  // Granted source has data but the credit limit is holding it off.
  assign w_stalled = ~w_credit_ok &
                     (((r_state == ST_GRANT0) & S0_AXIS_TVALID) |
                      ((r_state == ST_GRANT1) & S1_AXIS_TVALID));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pkt_count0   <= '0;
      r_pkt_count1   <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (w_accept && M_AXIS_TLAST && (r_state == ST_GRANT0)) begin
        r_pkt_count0 <= r_pkt_count0 + 32'd1;
      end
      if (w_accept && M_AXIS_TLAST && (r_state == ST_GRANT1)) begin
        r_pkt_count1 <= r_pkt_count1 + 32'd1;
      end
      if (w_stalled && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  assign pkt_count0   = r_pkt_count0;
  assign pkt_count1   = r_pkt_count1;
  assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_req_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_req_stream_arbiter
// Purpose  : Self-checking bench for req_stream_arbiter. A transaction-level
//            model (owner / turn / in-flight count) predicts every output on
//            every falling edge; directed scenarios add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_req_stream_arbiter;

  localparam int DW = 256;
  localparam int CW = 8;

  logic          clk;
  logic          resetn;
  logic          row_complete_in;
  logic [DW-1:0] S0_AXIS_TDATA;
  logic          S0_AXIS_TVALID;
  logic          S0_AXIS_TLAST;
  logic          S0_AXIS_TREADY;
  logic [DW-1:0] S1_AXIS_TDATA;
  logic          S1_AXIS_TVALID;
  logic          S1_AXIS_TLAST;
  logic          S1_AXIS_TREADY;
  logic [DW-1:0] M_AXIS_TDATA;
  logic          M_AXIS_TVALID;
  logic          M_AXIS_TLAST;
  logic          M_AXIS_TREADY;
  logic [CW-1:0] outstanding;
  logic          busy;
  logic          underflow_err;
`ifdef REQ_ARB_STATS_EN
  logic [31:0]   pkt_count0;
  logic [31:0]   pkt_count1;
  logic [31:0]   stall_cycles;
`endif

  req_stream_arbiter #(
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (16),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .row_complete_in (row_complete_in),
    .S0_AXIS_TDATA   (S0_AXIS_TDATA),
    .S0_AXIS_TVALID  (S0_AXIS_TVALID),
    .S0_AXIS_TLAST   (S0_AXIS_TLAST),
    .S0_AXIS_TREADY  (S0_AXIS_TREADY),
    .S1_AXIS_TDATA   (S1_AXIS_TDATA),
    .S1_AXIS_TVALID  (S1_AXIS_TVALID),
    .S1_AXIS_TLAST   (S1_AXIS_TLAST),
    .S1_AXIS_TREADY  (S1_AXIS_TREADY),
    .M_AXIS_TDATA    (M_AXIS_TDATA),
    .M_AXIS_TVALID   (M_AXIS_TVALID),
    .M_AXIS_TLAST    (M_AXIS_TLAST),
    .M_AXIS_TREADY   (M_AXIS_TREADY),
    .outstanding     (outstanding),
    .busy            (busy),
    .underflow_err   (underflow_err)
`ifdef REQ_ARB_STATS_EN
    ,
    .pkt_count0      (pkt_count0),
    .pkt_count1      (pkt_count1),
    .stall_cycles    (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Log of beats the DUT actually accepted, for ordering/timing checks.
  int            log_src[$];
  int            log_cyc[$];
  int            log_last[$];
  logic [DW-1:0] log_data[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mkdata(input int v);
    logic [31:0] w;
    w = v;
    return {8{w}};
  endfunction

  always @(posedge clk) cyc++;

  // ---------------- reference model ----------------
  // owner: -1 when no source holds the channel, else the granted source.
  // turn : which source wins the next tie.
  int m_owner = -1;
  int m_turn  = 0;
  int m_cnt   = 0;
  bit m_uf    = 1'b0;

  always @(negedge clk) begin
    logic [DW-1:0] e_data;
    logic e_last, e_valid, e_r0, e_r1, e_busy, acc, credit;
    int nxt;
    if (!resetn) begin
      m_owner = -1; m_turn = 0; m_cnt = 0; m_uf = 1'b0;
    end
    credit  = (m_cnt < 16);
    e_data  = '0; e_last = 1'b0; e_valid = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0;
    if (m_owner == 0) begin
      e_data = S0_AXIS_TDATA; e_last = S0_AXIS_TLAST;
      e_valid = S0_AXIS_TVALID && credit; e_r0 = M_AXIS_TREADY && credit;
    end else if (m_owner == 1) begin
      e_data = S1_AXIS_TDATA; e_last = S1_AXIS_TLAST;
      e_valid = S1_AXIS_TVALID && credit; e_r1 = M_AXIS_TREADY && credit;
    end
    e_busy = (m_owner != -1) || (m_cnt != 0);
    chk("m_tdata",  M_AXIS_TDATA, e_data);
    chk("m_tlast",  DW'(M_AXIS_TLAST), DW'(e_last));
    chk("m_tvalid", DW'(M_AXIS_TVALID), DW'(e_valid));
    chk("s0_tready", DW'(S0_AXIS_TREADY), DW'(e_r0));
    chk("s1_tready", DW'(S1_AXIS_TREADY), DW'(e_r1));
    chk("outstanding", DW'(outstanding), DW'(m_cnt));
    chk("busy", DW'(busy), DW'(e_busy));
    chk("underflow_err", DW'(underflow_err), DW'(m_uf));

    if (resetn) begin
      acc = e_valid && M_AXIS_TREADY;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        log_src.push_back(S1_AXIS_TREADY ? 1 : 0);
        log_cyc.push_back(cyc);
        log_last.push_back(M_AXIS_TLAST ? 1 : 0);
        log_data.push_back(M_AXIS_TDATA);
      end
      nxt = m_cnt + (acc ? 1 : 0) - (row_complete_in ? 1 : 0);
      if (nxt < 0) begin
        nxt  = 0;
        m_uf = 1'b1;
      end
      m_cnt = nxt;
      if (m_owner >= 0) begin
        if (acc && e_last) begin
          m_turn  = 1 - m_owner;
          m_owner = -1;
        end
      end else if (S0_AXIS_TVALID && S1_AXIS_TVALID) begin
        m_owner = m_turn;
      end else if (S0_AXIS_TVALID) begin
        m_owner = 0;
      end else if (S1_AXIS_TVALID) begin
        m_owner = 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int src, input logic v, input logic [DW-1:0] d, input logic l);
    if (src == 0) begin
      S0_AXIS_TVALID = v; S0_AXIS_TDATA = d; S0_AXIS_TLAST = l;
    end else begin
      S1_AXIS_TVALID = v; S1_AXIS_TDATA = d; S1_AXIS_TLAST = l;
    end
  endtask

  task automatic wait_hs(input int src);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (src == 0 && S0_AXIS_TVALID && S0_AXIS_TREADY) break;
      if (src == 1 && S1_AXIS_TVALID && S1_AXIS_TREADY) break;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL handshake_timeout src=%0d actual=none required=accept", src);
        break;
      end
    end
    tick();
  endtask

  task automatic send(input int src, input int npkt, input int nbeat, input int base);
    for (int p = 0; p < npkt; p++) begin
      for (int b = 0; b < nbeat; b++) begin
        drive(src, 1'b1, mkdata(base + p * nbeat + b), (b == nbeat - 1));
        wait_hs(src);
      end
    end
    drive(src, 1'b0, '0, 1'b0);
  endtask

  task automatic reset_dut();
    resetn = 1'b0;
    row_complete_in = 1'b0;
    M_AXIS_TREADY = 1'b1;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int s;
    int n;
    int exp_src[8];
    int exp_gap[7];
    resetn = 1'b0;
    row_complete_in = 1'b0;
    M_AXIS_TREADY = 1'b1;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);

    // Reset state
    #2;
    chk("rst_m_tvalid", DW'(M_AXIS_TVALID), DW'(1'b0));
    chk("rst_outstanding", DW'(outstanding), DW'(0));
    reset_dut();

    // 1: single 3-beat packet from S0
    s = log_src.size();
    send(0, 1, 3, 'h100);
    tick();
    chk("t1_beats", DW'(log_src.size() - s), DW'(3));
    for (int i = 0; i < 3; i++) begin
      if (s + i < log_src.size()) begin
        chk("t1_src", DW'(log_src[s+i]), DW'(0));
        chk("t1_data", log_data[s+i], mkdata('h100 + i));
        chk("t1_last", DW'(log_last[s+i]), DW'(i == 2));
      end
    end
    chk("t1_outstanding", DW'(outstanding), DW'(3));

    // 2: both sources continuously valid, 2-beat packets, 4 completions
    reset_dut();
    s = log_src.size();
    fork
      send(0, 2, 2, 'h200);
      send(1, 2, 2, 'h300);
      begin
        repeat (6) tick();
        row_complete_in = 1'b1;
        repeat (4) tick();
        row_complete_in = 1'b0;
      end
    join
    tick();
    exp_src = '{0, 0, 1, 1, 0, 0, 1, 1};
    exp_gap = '{1, 2, 1, 2, 1, 2, 1};
    chk("t2_beats", DW'(log_src.size() - s), DW'(8));
    if (log_src.size() - s == 8) begin
      for (int i = 0; i < 8; i++) chk("t2_order", DW'(log_src[s+i]), DW'(exp_src[i]));
      for (int i = 0; i < 7; i++) chk("t2_gap", DW'(log_cyc[s+i+1] - log_cyc[s+i]), DW'(exp_gap[i]));
    end
    chk("t2_outstanding", DW'(outstanding), DW'(4));

    // 3: credit limit with 20 single-beat packets
    reset_dut();
    s = log_src.size();
    fork
      send(0, 20, 1, 'h400);
      begin
        n = 0;
        while (outstanding != 8'd16 && n < 100) begin
          @(negedge clk);
          n++;
        end
        repeat (3) tick();
        chk("t3_outstanding_cap", DW'(outstanding), DW'(16));
        chk("t3_accepted", DW'(log_src.size() - s), DW'(16));
        chk("t3_tvalid_blocked", DW'(M_AXIS_TVALID), DW'(1'b0));
        chk("t3_tready_blocked", DW'(S0_AXIS_TREADY), DW'(1'b0));
        row_complete_in = 1'b1;
        tick();
        row_complete_in = 1'b0;
        @(negedge clk);
        chk("t3_outstanding_after", DW'(outstanding), DW'(15));
        chk("t3_resume_valid", DW'(M_AXIS_TVALID), DW'(1'b1));
        tick();
        row_complete_in = 1'b1;
        repeat (10) tick();
        row_complete_in = 1'b0;
      end
    join
    chk("t3_total", DW'(log_src.size() - s), DW'(20));

    // 4: completion coincident with an accept at outstanding = 5
    reset_dut();
    send(0, 5, 1, 'h500);
    chk("t4_pre", DW'(outstanding), DW'(5));
    drive(0, 1'b1, mkdata('h5AA), 1'b1);
    tick();
    row_complete_in = 1'b1;
    @(negedge clk);
    chk("t4_accept", DW'(M_AXIS_TVALID && M_AXIS_TREADY), DW'(1'b1));
    tick();
    row_complete_in = 1'b0;
    drive(0, 1'b0, '0, 1'b0);
    chk("t4_outstanding", DW'(outstanding), DW'(5));

    // 5: underflow, sticky through traffic (with backpressure), cleared by reset
    reset_dut();
    row_complete_in = 1'b1;
    tick();
    row_complete_in = 1'b0;
    chk("t5_cnt_hold", DW'(outstanding), DW'(0));
    chk("t5_uf_set", DW'(underflow_err), DW'(1'b1));
    fork
      send(1, 1, 3, 'h600);
      begin
        M_AXIS_TREADY = 1'b0;
        repeat (3) tick();
        M_AXIS_TREADY = 1'b1;
      end
    join
    tick();
    chk("t5_uf_sticky", DW'(underflow_err), DW'(1'b1));
    chk("t5_cnt", DW'(outstanding), DW'(3));
    reset_dut();
    chk("t5_uf_clear", DW'(underflow_err), DW'(1'b0));

    // 6: async reset mid-packet in GRANT1 with 7 outstanding
    reset_dut();
    drive(1, 1'b1, mkdata('h700), 1'b0);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #2;
      if (outstanding == 8'd7) break;
      n++;
    end
    chk("t6_pre_cnt", DW'(outstanding), DW'(7));
    chk("t6_pre_valid", DW'(M_AXIS_TVALID), DW'(1'b1));
    #1 resetn = 1'b0;
    drive(0, 1'b1, mkdata('h800), 1'b1);
    #1;
    chk("t6_async_valid", DW'(M_AXIS_TVALID), DW'(1'b0));
    chk("t6_async_ready", DW'(S1_AXIS_TREADY), DW'(1'b0));
    chk("t6_async_data", M_AXIS_TDATA, '0);
    chk("t6_async_cnt", DW'(outstanding), DW'(0));
    chk("t6_async_busy", DW'(busy), DW'(1'b0));
    tick();
    s = log_src.size();
    resetn = 1'b1;
    n = 0;
    while (log_src.size() == s && n < 10) begin
      tick();
      n++;
    end
    chk("t6_first_grant_present", DW'(log_src.size() > s), DW'(1'b1));
    if (log_src.size() > s) chk("t6_first_grant_src", DW'(log_src[s]), DW'(0));
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
